// File: rtl/sprite_drawer.sv
// rtl/sprite_drawer.sv - CHIP-8 framebuffer write engine for DXYN sprite draws and 00E0 clears
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   start_in, clear_in        1-cycle draw / clear requests, sampled only when idle
//   x_in, y_in, n_in          sprite column (VX), row (VY), height in rows
//   sprite_addr_in            I register, first sprite byte address
//   mem_addr_out, mem_data_in CHIP-8 RAM read port (1-cycle read latency)
//   fb_addr_out, fb_data_in   framebuffer read port (1-cycle read latency), addr = {row, xbyte}
//   fb_data_out, fb_we_out    framebuffer write port
//   busy_out, done_out        activity flag, 1-cycle completion pulse
//   collision_out             VF result of the last draw

module sprite_drawer #(
    parameter bit WRAP = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        clear_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] sprite_addr_in,
    output logic [11:0] mem_addr_out,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  fb_addr_out,
    input  logic [7:0]  fb_data_in,
    output logic [7:0]  fb_data_out,
    output logic        fb_we_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        collision_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_RD0, S_WR0, S_RD1, S_WR1, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  shift_q, shift_d;
    logic [2:0]  xb_q, xb_d;
    logic [4:0]  y0_q, y0_d;
    logic [3:0]  n_q, n_d;
    logic [11:0] i_q, i_d;
    logic [3:0]  r_q, r_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  ctr_q, ctr_d;
    logic        coll_q, coll_d;
    logic [11:0] mem_hold_q, mem_hold_d;
    logic [7:0]  fb_hold_q, fb_hold_d;

    logic [5:0]  row_y;
    logic        row_clip;
    logic [7:0]  m0, m1;
    logic        need_second;
    logic [3:0]  r_inc;
    logic        unused_ok;

    // Only the low 6 bits of VX and 5 bits of VY matter: the start point always wraps.
    assign unused_ok = &{1'b0, x_in[7:6], y_in[7:5]};

    // Row y can exceed 31 only through the row offset; bit 5 flags that overflow.
    assign row_y       = {1'b0, y0_q} + {2'b00, r_q};
    assign row_clip    = !WRAP && row_y[5];
    assign m0          = s_q >> shift_q;
    assign m1          = s_q << (4'd8 - {1'b0, shift_q});
    assign need_second = (shift_q != 3'd0) && (WRAP || (xb_q != 3'd7));
    assign r_inc       = r_q + 4'd1;

    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = (state_q == S_DONE);
    assign collision_out = coll_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        xb_d         = xb_q;
        y0_d         = y0_q;
        n_d          = n_q;
        i_d          = i_q;
        r_d          = r_q;
        s_d          = s_q;
        ctr_d        = ctr_q;
        coll_d       = coll_q;
        mem_addr_out = mem_hold_q;
        fb_addr_out  = fb_hold_q;
        fb_data_out  = 8'h00;
        fb_we_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_in) begin
                    ctr_d   = 8'h00;
                    state_d = S_CLEAR;
                end else if (start_in) begin
                    shift_d = x_in[2:0];
                    xb_d    = x_in[5:3];
                    y0_d    = y_in[4:0];
                    n_d     = n_in;
                    i_d     = sprite_addr_in;
                    r_d     = 4'd0;
                    coll_d  = 1'b0;
                    state_d = (n_in == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_CLEAR: begin
                fb_we_out   = 1'b1;
                fb_addr_out = ctr_q;
                ctr_d       = ctr_q + 8'd1;
                if (ctr_q == 8'hFF) state_d = S_DONE;
            end
            S_FETCH: begin
                mem_addr_out = i_q + {8'h00, r_q};
                state_d      = row_clip ? S_DONE : S_RD0;
            end
            S_RD0: begin
                s_d         = mem_data_in;
                fb_addr_out = {row_y[4:0], xb_q};
                state_d     = S_WR0;
            end
            S_WR0: begin
                // Address is still held from RD0, so the write lands on the byte just read.
                fb_we_out   = 1'b1;
                fb_data_out = fb_data_in ^ m0;
                coll_d      = coll_q | (|(fb_data_in & m0));
                if (need_second) begin
                    state_d = S_RD1;
                end else begin
                    r_d     = r_inc;
                    state_d = (r_inc == n_q) ? S_DONE : S_FETCH;
                end
            end
            S_RD1: begin
                fb_addr_out = {row_y[4:0], xb_q + 3'd1};
                state_d     = S_WR1;
            end
            S_WR1: begin
                fb_we_out   = 1'b1;
                fb_data_out = fb_data_in ^ m1;
                coll_d      = coll_q | (|(fb_data_in & m1));
                r_d         = r_inc;
                state_d     = (r_inc == n_q) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_hold_d = mem_addr_out;
        fb_hold_d  = fb_addr_out;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            shift_q    <= 3'd0;
            xb_q       <= 3'd0;
            y0_q       <= 5'd0;
            n_q        <= 4'd0;
            i_q        <= 12'h000;
            r_q        <= 4'd0;
            s_q        <= 8'h00;
            ctr_q      <= 8'h00;
            coll_q     <= 1'b0;
            mem_hold_q <= 12'h000;
            fb_hold_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            xb_q       <= xb_d;
            y0_q       <= y0_d;
            n_q        <= n_d;
            i_q        <= i_d;
            r_q        <= r_d;
            s_q        <= s_d;
            ctr_q      <= ctr_d;
            coll_q     <= coll_d;
            mem_hold_q <= mem_hold_d;
            fb_hold_q  <= fb_hold_d;
        end
    end

endmodule
